// File: rtl/bfsk_pkg.sv
// Shared BFSK definitions: sample type and default symbol/slicer constants.
// The modulator uses the same package.
package bfsk_pkg;

   localparam int W      = 8;
   localparam int SPS    = 32;
   localparam int MID    = 128;
   localparam int HYST   = 0;
   localparam int THRESH = 3;
   localparam int CNT_W  = $clog2(SPS + 1);

   typedef logic [W-1:0] sample_t;

endpackage

// File: rtl/bfsk_slicer.sv
// Hysteresis comparator with its level register.
// Flags a transition for any accepted sample that flips the level.
module bfsk_slicer
   import bfsk_pkg::*;
#(
   parameter int W    = bfsk_pkg::W,
   parameter int MID  = bfsk_pkg::MID,
   parameter int HYST = bfsk_pkg::HYST
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] sample,
   input  logic         valid,
   output logic         lvl,
   output logic         trans
);

   // Thresholds saturate so a wide band never wraps around the sample range.
   localparam int MAXV = (1 << W) - 1;
   localparam int HI   = (MID + HYST > MAXV) ? MAXV : MID + HYST;
   localparam int LO   = (MID - HYST < 0) ? 0 : MID - HYST;
   localparam logic [W-1:0] HI_V = W'(HI);
   localparam logic [W-1:0] LO_V = W'(LO);

   logic lvl_next;

   always_comb begin
      lvl_next = lvl;
      if (sample >= HI_V)
         lvl_next = 1'b1;
      else if (sample < LO_V)
         lvl_next = 1'b0;
   end

   assign trans = valid && (lvl_next != lvl);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         lvl <= 1'b0;
      else if (valid)
         lvl <= lvl_next;
   end

endmodule

// File: rtl/bfsk_demod.sv
// BFSK demodulator: counts slicer transitions over each SPS-sample window
// and decides one bit per window.
module bfsk_demod
   import bfsk_pkg::*;
#(
   parameter int W      = bfsk_pkg::W,
   parameter int SPS    = bfsk_pkg::SPS,
   parameter int MID    = bfsk_pkg::MID,
   parameter int HYST   = bfsk_pkg::HYST,
   parameter int THRESH = bfsk_pkg::THRESH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [W-1:0]               sample,
   input  logic                       sample_valid,
   input  logic                       sym_start,
   output logic                       bit_out,
   output logic                       bit_valid,
   output logic                       no_carrier,
   output logic [$clog2(SPS+1)-1:0]   cross_cnt
);

   localparam int CW = $clog2(SPS + 1);
   localparam int IW = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [IW-1:0] LAST = IW'(SPS - 1);
   localparam logic [CW-1:0] THR  = CW'(THRESH);

   logic [IW-1:0] idx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          trans;

   bfsk_slicer #(
      .W    (W),
      .MID  (MID),
      .HYST (HYST)
   ) u_slicer (
      .clk    (clk),
      .reset  (reset),
      .sample (sample),
      .valid  (sample_valid),
      .lvl    (),
      .trans  (trans)
   );

   assign cnt_next = cnt + CW'(trans);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx        <= '0;
         cnt        <= '0;
         bit_out    <= 1'b0;
         bit_valid  <= 1'b0;
         no_carrier <= 1'b0;
         cross_cnt  <= '0;
      end else begin
         bit_valid <= 1'b0;
         // Resync wins over a pending decision; its sample opens the new window.
         if (sym_start) begin
            cnt <= CW'(trans);
            idx <= sample_valid ? IW'(1) : '0;
         end else if (sample_valid) begin
            if (idx == LAST) begin
               bit_out    <= (cnt_next >= THR);
               cross_cnt  <= cnt_next;
               no_carrier <= (cnt_next == '0);
               bit_valid  <= 1'b1;
               cnt        <= '0;
               idx        <= '0;
            end else begin
               cnt <= cnt_next;
               idx <= idx + IW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bfsk_demod.sv
// Directed bench for bfsk_demod: tone windows, silence, gaps, resync, reset.
module tb_bfsk_demod;

   localparam real PI = 3.14159265358979;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] sample = '0;
   logic       sample_valid = 1'b0;
   logic       sym_start = 1'b0;
   logic       bit_out;
   logic       bit_valid;
   logic       no_carrier;
   logic [5:0] cross_cnt;

   int checks = 0;
   int errors = 0;
   logic [8:0] obs;
   logic [8:0] exp_v;
   int early;

   always #5 clk = ~clk;

   bfsk_demod #(
      .W      (8),
      .SPS    (32),
      .MID    (128),
      .HYST   (0),
      .THRESH (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sym_start    (sym_start),
      .bit_out      (bit_out),
      .bit_valid    (bit_valid),
      .no_carrier   (no_carrier),
      .cross_cnt    (cross_cnt)
   );

   // tone 0: 1000 Hz, tone 1: 1500 Hz (phase 0/1), 2: silence
   function automatic logic [7:0] tone_sample(input int tone, input int phase, input int n);
      real x;
      x = 0.0;
      if (tone == 0)
         x = 127.0 * $sin(2.0 * PI * n / 32.0);
      else if (tone == 1)
         x = 127.0 * $sin(3.0 * PI * n / 32.0 + PI * phase);
      if (tone == 2)
         return 8'd0;
      return 8'($rtoi(128.0 + x + 0.5));
   endfunction

   task automatic feed(input logic [7:0] s, input logic v, input logic ss);
      @(negedge clk);
      sample = s;
      sample_valid = v;
      sym_start = ss;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      sample_valid = 1'b0;
      sym_start = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic feed_window(input int tone, input int phase, input bit gap,
                              input bit ss_first, output int n_early);
      n_early = 0;
      for (int n = 0; n < 32; n++) begin
         if (gap) begin
            feed(8'h00, 1'b0, 1'b0);
            if (bit_valid) n_early++;
         end
         feed(tone_sample(tone, phase, n), 1'b1, ss_first && (n == 0));
         if (n < 31 && bit_valid) n_early++;
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      sample = 8'd200;
      sample_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      obs = {bit_valid, bit_out, no_carrier, cross_cnt};
      checks++;
      if (obs !== 9'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required %b", obs, 9'b0);
      end
      @(negedge clk);
      sample_valid = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_tone0();
      do_reset();
      feed_window(0, 0, 1'b0, 1'b0, early);
      obs = {bit_valid, bit_out, no_carrier, cross_cnt};
      exp_v = {1'b1, 1'b0, 1'b0, 6'd2};
      checks++;
      if (obs !== exp_v || early != 0) begin
         errors++;
         $display("FAIL tone0_decision: got %b early=%0d required %b early=0", obs, early, exp_v);
      end
      feed(8'h00, 1'b0, 1'b0);
      obs = {bit_valid, bit_out, no_carrier, cross_cnt};
      exp_v = {1'b0, 1'b0, 1'b0, 6'd2};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL tone0_hold: got %b required %b", obs, exp_v);
      end
   endtask

   task automatic test_tone1_pair();
      do_reset();
      for (int p = 0; p < 2; p++) begin
         feed_window(1, p, 1'b0, 1'b0, early);
         obs = {bit_valid, bit_out, no_carrier, cross_cnt};
         exp_v = {1'b1, 1'b1, 1'b0, 6'd3};
         checks++;
         if (obs !== exp_v || early != 0) begin
            errors++;
            $display("FAIL tone1_phase%0d: got %b early=%0d required %b early=0", p, obs, early, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      int tones [3] = '{0, 1, 0};
      logic [8:0] exps [3] = '{{1'b1, 1'b0, 1'b0, 6'd2},
                               {1'b1, 1'b1, 1'b0, 6'd3},
                               {1'b1, 1'b0, 1'b0, 6'd1}};
      do_reset();
      for (int w = 0; w < 3; w++) begin
         feed_window(tones[w], 0, 1'b0, 1'b0, early);
         obs = {bit_valid, bit_out, no_carrier, cross_cnt};
         checks++;
         if (obs !== exps[w] || early != 0) begin
            errors++;
            $display("FAIL mixed_window%0d: got %b early=%0d required %b early=0", w, obs, early, exps[w]);
         end
      end
   endtask

   task automatic test_silence();
      do_reset();
      feed_window(2, 0, 1'b0, 1'b0, early);
      obs = {bit_valid, bit_out, no_carrier, cross_cnt};
      exp_v = {1'b1, 1'b0, 1'b1, 6'd0};
      checks++;
      if (obs !== exp_v || early != 0) begin
         errors++;
         $display("FAIL silence: got %b early=%0d required %b early=0", obs, early, exp_v);
      end
   endtask

   task automatic test_gapped();
      do_reset();
      feed_window(0, 0, 1'b1, 1'b0, early);
      obs = {bit_valid, bit_out, no_carrier, cross_cnt};
      exp_v = {1'b1, 1'b0, 1'b0, 6'd2};
      checks++;
      if (obs !== exp_v || early != 0) begin
         errors++;
         $display("FAIL gapped_decision: got %b early=%0d required %b early=0", obs, early, exp_v);
      end
      feed(8'h00, 1'b0, 1'b0);
      checks++;
      if (bit_valid !== 1'b0) begin
         errors++;
         $display("FAIL gapped_pulse_width: got bit_valid=%b required 0", bit_valid);
      end
   endtask

   task automatic test_resync();
      int n_pulse;
      do_reset();
      n_pulse = 0;
      for (int n = 0; n < 10; n++) begin
         feed(tone_sample(0, 0, n), 1'b1, 1'b0);
         if (bit_valid) n_pulse++;
      end
      // idx 10 restarts the window with the 1500 Hz phase-1 tone
      feed_window(1, 1, 1'b0, 1'b1, early);
      obs = {bit_valid, bit_out, no_carrier, cross_cnt};
      exp_v = {1'b1, 1'b1, 1'b0, 6'd3};
      checks++;
      if (obs !== exp_v || early != 0 || n_pulse != 0) begin
         errors++;
         $display("FAIL resync_window: got %b early=%0d partial=%0d required %b 0 0",
                  obs, early, n_pulse, exp_v);
      end
      for (int n = 0; n < 31; n++) feed(8'd200, 1'b1, 1'b0);
      feed(8'd200, 1'b1, 1'b1);
      checks++;
      if (bit_valid !== 1'b0) begin
         errors++;
         $display("FAIL resync_priority: got bit_valid=%b required 0", bit_valid);
      end
      n_pulse = 0;
      for (int n = 0; n < 31; n++) begin
         feed(8'd50, 1'b1, 1'b0);
         if (n < 30 && bit_valid) n_pulse++;
      end
      obs = {bit_valid, bit_out, no_carrier, cross_cnt};
      exp_v = {1'b1, 1'b0, 1'b0, 6'd1};
      checks++;
      if (obs !== exp_v || n_pulse != 0) begin
         errors++;
         $display("FAIL resync_after_priority: got %b early=%0d required %b early=0", obs, n_pulse, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      feed_window(1, 0, 1'b0, 1'b0, early);
      obs = {bit_valid, bit_out, no_carrier, cross_cnt};
      exp_v = {1'b1, 1'b1, 1'b0, 6'd3};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_mid_pre: got %b required %b", obs, exp_v);
      end
      for (int n = 0; n < 20; n++) feed(tone_sample(0, 0, n), 1'b1, 1'b0);
      reset = 1'b0;
      #1;
      obs = {bit_valid, bit_out, no_carrier, cross_cnt};
      checks++;
      if (obs !== 9'b0) begin
         errors++;
         $display("FAIL reset_mid_async: got %b required %b", obs, 9'b0);
      end
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      feed_window(0, 0, 1'b0, 1'b0, early);
      obs = {bit_valid, bit_out, no_carrier, cross_cnt};
      exp_v = {1'b1, 1'b0, 1'b0, 6'd2};
      checks++;
      if (obs !== exp_v || early != 0) begin
         errors++;
         $display("FAIL reset_mid_recover: got %b early=%0d required %b early=0", obs, early, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_tone0();
      test_tone1_pair();
      test_back_to_back();
      test_silence();
      test_gapped();
      test_resync();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bfsk_demod.md
Name: bfsk_demod

Overview:
- Receive-side counterpart of the team's BFSK sine modulator. Each symbol is 32 samples long.
- Tone "0" is one sine cycle per symbol (1000 Hz). Tone "1" is 1.5 cycles per symbol (1500 Hz), and its phase alternates between symbols.
- Consumes unsigned 8-bit samples, offset-binary around MID. Slices each sample to a level, counts level transitions across each symbol window, and emits one decided bit per window.
- Sits between the ADC/sample source and the bit sink.

Parameters:
- W, 8: sample width.
- SPS, 32: valid samples per symbol.
- MID, 128: slicer midpoint.
- HYST, 0: slicer hysteresis half-band. 0 means plain compare, sample >= MID.
- THRESH, 3: minimum transition count per window that decides bit 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample  in  W  input sample.
- sample_valid  in  1  sample qualifier; one sample accepted per cycle when high.
- sym_start  in  1  resync: the current cycle begins a new window.
- bit_out  out  1  decided bit, held until the next decision.
- bit_valid  out  1  one-cycle pulse marking a new bit_out.
- no_carrier  out  1  last window had zero transitions.
- cross_cnt  out  $clog2(SPS+1)  transition count of the last window, held.

Behaviour:
- Reset (reset=0, asynchronous): clear the following, all to 0:
  - outputs bit_out, bit_valid, no_carrier, cross_cnt;
  - sample index idx, running count cnt, and the slicer level register lvl (0 = low).
- Slicer (on accepted sample s):
  - next level = 1 if s >= MID+HYST; 0 if s < MID-HYST; otherwise hold lvl.
  - Compute MID±HYST with saturation at 0 and 2^W-1.
- Transition: an accepted sample whose next level differs from lvl.
  - cnt_next = cnt + transition.
  - lvl updates on every accepted sample and is NOT cleared at window boundaries.
- Window counter: idx increments on each accepted sample and wraps SPS-1 -> 0.
- Decision, when the sample with idx==SPS-1 is accepted. On the next clock edge (latency 1 cycle from the last sample):
  - bit_out = (cnt_next >= THRESH)
  - cross_cnt = cnt_next
  - no_carrier = (cnt_next == 0)
  - bit_valid = 1 for exactly one cycle
  - cnt = 0, idx = 0
- sample_valid=0: idx, cnt and lvl hold. bit_valid deasserts after its single cycle. Gaps of any length are legal.
- sym_start=1:
  - The partial window is discarded with no bit_valid.
  - cnt and idx clear. If sample_valid is also high, that sample is idx 0 of the new window: it is counted, and idx becomes 1.
  - sym_start has priority over the decision at idx==SPS-1: no decision is emitted.
  - lvl is kept.
- Counter width: $clog2(SPS+1); cnt cannot exceed SPS, so there is no overflow.
- Reset asserted mid-window: all state clears immediately, and any pending bit_valid is suppressed.

Decomposition:
- Package bfsk_pkg holds:
  - typedef sample_t (logic [W-1:0]);
  - constants SPS, MID, THRESH and CNT_W = $clog2(SPS+1).
  - The modulator may share this package.
- One sub-module, bfsk_slicer: the hysteresis comparator plus the lvl register. It outputs lvl and a transition strobe.
- Window counter, transition accumulator and decision register stay in bfsk_demod.

Test Plan:
- 1000 Hz window: reset, then 32 valid samples 128,153,177,...,103 (one cycle, starting upward) -> one bit_valid pulse 1 cycle after the 32nd sample; bit_out=0, cross_cnt=2, no_carrier=0.
- 1500 Hz pair: the phase-0 window (128,165,199,...,199,165) followed by the phase-1 window (128,91,57,...,57,91) -> two bits 1, 1 with cross_cnt 3 then 3.
- Mixed 1000 / 1500 / 1000 (the first window starts upward, the second is the 1.5-cycle tone's phase-0 window, starting upward):
  - bits 0, 1, 0 with cross_cnt 2, 3, 1;
  - this checks that lvl carries across window boundaries.
- Silence: 32 samples of value 0 after reset -> bit_out=0, cross_cnt=0, no_carrier=1.
- Gapped input: the 1000 Hz window with sample_valid toggling every cycle -> identical result to the first scenario; bit_valid only after the 32nd valid sample; no pulse during gaps.
- Resync and reset:
  - sym_start at idx 10 -> no bit_valid for the partial window; the next 32 samples decide correctly.
  - reset=0 at idx 20 -> all outputs 0 at once; the next full window decides correctly.
